// File: rtl/config_pkg.sv
// config_pkg: shared Q8.8 fixed-point vector types, operation codes and
// the lane-count legality check for the row-wise vector units.
package config_pkg;
   localparam int D = 8;
   localparam int W = 16;
   localparam int FRAC = 8;
   typedef logic signed [W-1:0] fixed_point_t;
   typedef fixed_point_t [D-1:0] vector_t;
   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_DIV = 3'd3,
      OP_EXP = 3'd4,
      OP_SIG = 3'd5
   } operation_t;
   localparam fixed_point_t ONE = fixed_point_t'(1 << FRAC);
   function automatic bit lanes_ok(int lanes);
      return lanes > 0 && D % lanes == 0;
   endfunction
endpackage

// File: rtl/rowwise_add.sv
// rowwise_add: fixed-point element add, wraps on overflow.
module rowwise_add
   import config_pkg::*;
(
   input  fixed_point_t a,
   input  fixed_point_t b,
   output fixed_point_t y
);
   assign y = a + b;
endmodule

// File: rtl/rowwise_div.sv
// rowwise_div: fixed-point element divide, truncating; divide by zero yields 0.
module rowwise_div
   import config_pkg::*;
(
   input  fixed_point_t a,
   input  fixed_point_t b,
   output fixed_point_t y
);
   assign y = (b == '0) ? '0 : fixed_point_t'((32'(a) <<< FRAC) / 32'(b));
endmodule

// File: rtl/rowwise_exp.sv
// rowwise_exp: second-order approximation 1 + x + x^2/2 of exp(x).
module rowwise_exp
   import config_pkg::*;
(
   input  fixed_point_t a,
   output fixed_point_t y
);
   assign y = fixed_point_t'(32'(ONE) + 32'(a) + ((32'(a) * 32'(a)) >>> (FRAC + 1)));
endmodule

// File: rtl/rowwise_lane.sv
// rowwise_lane: combinational single-element ALU over the rowwise_* units;
// unknown operation codes give 0 and raise illegal.
module rowwise_lane
   import config_pkg::*;
(
   input  fixed_point_t a,
   input  fixed_point_t b,
   input  operation_t   op,
   output fixed_point_t y,
   output logic         illegal
);
   fixed_point_t y_add, y_sub, y_mul, y_div, y_exp, y_sig;
   rowwise_add u_add (.a(a), .b(b), .y(y_add));
   rowwise_sub u_sub (.a(a), .b(b), .y(y_sub));
   rowwise_mul u_mul (.a(a), .b(b), .y(y_mul));
   rowwise_div u_div (.a(a), .b(b), .y(y_div));
   rowwise_exp u_exp (.a(a), .y(y_exp));
   rowwise_sig u_sig (.a(a), .y(y_sig));
   always_comb begin
      y = '0;
      illegal = 1'b0;
      case (op)
         OP_ADD:  y = y_add;
         OP_SUB:  y = y_sub;
         OP_MUL:  y = y_mul;
         OP_DIV:  y = y_div;
         OP_EXP:  y = y_exp;
         OP_SIG:  y = y_sig;
         default: illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/rowwise_mul.sv
// rowwise_mul: fixed-point element multiply, product floored back to Q8.8.
module rowwise_mul
   import config_pkg::*;
(
   input  fixed_point_t a,
   input  fixed_point_t b,
   output fixed_point_t y
);
   assign y = fixed_point_t'((32'(a) * 32'(b)) >>> FRAC);
endmodule

// File: rtl/rowwise_sig.sv
// rowwise_sig: hard sigmoid 0.5 + x/4 clamped to [0, 1].
module rowwise_sig
   import config_pkg::*;
(
   input  fixed_point_t a,
   output fixed_point_t y
);
   fixed_point_t t;
   assign t = (ONE >>> 1) + (a >>> 2);
   assign y = t[W-1] ? '0 : (t > ONE ? ONE : t);
endmodule

// File: rtl/rowwise_sub.sv
// rowwise_sub: fixed-point element subtract, wraps on overflow.
module rowwise_sub
   import config_pkg::*;
(
   input  fixed_point_t a,
   input  fixed_point_t b,
   output fixed_point_t y
);
   assign y = a - b;
endmodule

// File: rtl/rowwise_operation_lanes.sv
// rowwise_operation_lanes: element-wise vector ALU, LANES elements per beat,
// with its own result register and a valid/ready result handshake.
module rowwise_operation_lanes
   import config_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  vector_t    a_i,
   input  vector_t    b_i,
   input  operation_t operation_i,
   input  logic       bcast_b_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   output vector_t    result_o,
   output logic       err_o,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output logic       busy_o
);
   localparam int BEATS = D / LANES;
   localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
   localparam int IW = D > 1 ? $clog2(D) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   if (!lanes_ok(LANES)) begin : g_bad_lanes
      $error("rowwise_operation_lanes: LANES must divide D");
   end

   state_t       state, state_nx;
   logic [CW-1:0] cnt;
   vector_t      a_q, b_q, res_q;
   operation_t   op_q;
   logic         bcast_q, err_q, accept, last;
   fixed_point_t y [LANES];
   logic [IW-1:0] idx [LANES];
   logic [LANES-1:0] ill;

   assign in_ready_o  = state == IDLE;
   assign out_valid_o = state == DONE;
   assign busy_o      = state != IDLE;
   assign result_o    = res_q;
   assign err_o       = err_q;
   assign accept      = in_valid_i && in_ready_o;
   assign last        = cnt == CW'(BEATS - 1);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign idx[g] = IW'(cnt) * IW'(LANES) + IW'(g);
      rowwise_lane u_lane (
         .a      (a_q[idx[g]]),
         .b      (bcast_q ? b_q[0] : b_q[idx[g]]),
         .op     (op_q),
         .y      (y[g]),
         .illegal(ill[g])
      );
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = (state == IDLE && in_valid_i)  ? RUN  :
                 (state == RUN && last)         ? DONE :
                 (state == DONE && out_ready_i) ? IDLE : state;
   end

   // Operands are captured once at acceptance; RUN only touches the counter and result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_ADD;
         bcast_q <= 1'b0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         cnt     <= '0;
         a_q     <= a_i;
         b_q     <= b_i;
         op_q    <= operation_i;
         bcast_q <= bcast_b_i;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else if (state == RUN) begin
         cnt   <= cnt + CW'(1);
         err_q <= err_q | (|ill);
         for (int l = 0; l < LANES; l++) res_q[idx[l]] <= y[l];
      end
   end
endmodule

// File: tb/tb_rowwise_operation_lanes.sv
// tb_rowwise_operation_lanes: scoreboard bench; a LANES=2 instance carries most
// scenarios and a LANES=8 instance covers the single-beat broadcast case.
module tb_rowwise_operation_lanes;
   import config_pkg::*;
   typedef struct { vector_t res; logic err; } exp_t;

   logic clk = 1'b0, rst_n = 1'b0;
   vector_t a = '0, b = '0;
   operation_t op = OP_ADD;
   logic bcast = 1'b0, in_valid = 1'b0, out_ready = 1'b1, in_valid8 = 1'b0, out_ready8 = 1'b1;
   logic in_ready, out_valid, err, busy, in_ready8, out_valid8, err8, busy8;
   vector_t result, result8;
   exp_t sb[$];
   int passed = 0, total = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rowwise_operation_lanes #(.LANES(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .a_i(a), .b_i(b), .operation_i(op), .bcast_b_i(bcast),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .result_o(result), .err_o(err),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
   );

   rowwise_operation_lanes #(.LANES(8)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .a_i(a), .b_i(b), .operation_i(op), .bcast_b_i(bcast),
      .in_valid_i(in_valid8), .in_ready_o(in_ready8), .result_o(result8), .err_o(err8),
      .out_valid_o(out_valid8), .out_ready_i(out_ready8), .busy_o(busy8)
   );

   function automatic fixed_point_t m_el(fixed_point_t x, fixed_point_t y, operation_t o);
      case (o)
         OP_ADD:  return x + y;
         OP_SUB:  return x - y;
         OP_MUL:  return fixed_point_t'((int'(x) * int'(y)) >>> FRAC);
         OP_DIV:  return (y == 0) ? '0 : fixed_point_t'((int'(x) * 256) / int'(y));
         default: return '0;
      endcase
   endfunction

   function automatic exp_t model(vector_t x, vector_t y, operation_t o);
      exp_t r;
      r.err = 1'b0;
      for (int i = 0; i < D; i++) r.res[i] = m_el(x[i], y[i], o);
      return r;
   endfunction

   // Presents one request at a negedge while the LANES=2 instance is idle.
   task automatic send(input vector_t x, input vector_t y, input operation_t o, input exp_t ex);
      a = x; b = y; op = o; bcast = 1'b0; in_valid = 1'b1;
      sb.push_back(ex);
      @(negedge clk);
      in_valid = 1'b0;
      a = '1; b = '1;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
      total++; if (result !== '0) $display("FAIL reset_result got %h want 0", result); else passed++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add;
      vector_t x, y;
      exp_t ex, e;
      int run = 0;
      for (int i = 0; i < D; i++) begin
         x[i] = 16'sh0180; y[i] = 16'sh0240; ex.res[i] = 16'sh03C0;
      end
      ex.err = 1'b0;
      out_ready = 1'b1;
      send(x, y, OP_ADD, ex);
      while (busy && !out_valid && run < 20) begin run++; @(negedge clk); end
      total++; if (run !== 4) $display("FAIL add_run_cycles got %0d want 4", run); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL add_valid got %b want 1", out_valid); else passed++;
      e = sb.pop_front();
      total++; if (result !== e.res) $display("FAIL add_result got %h want %h", result, e.res); else passed++;
      total++; if (err !== e.err) $display("FAIL add_err got %b want %b", err, e.err); else passed++;
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL add_pulse got valid=%b ready=%b want 0/1", out_valid, in_ready); else passed++;
   endtask

   task automatic test_bcast;
      exp_t ex, e;
      int run = 0;
      for (int i = 0; i < D; i++) begin
         a[i] = fixed_point_t'(i * 256);
         b[i] = (i == 0) ? 16'sh0100 : fixed_point_t'($urandom);
         ex.res[i] = fixed_point_t'((i - 1) * 256);
      end
      ex.err = 1'b0;
      op = OP_SUB; bcast = 1'b1; in_valid8 = 1'b1;
      sb.push_back(ex);
      @(negedge clk);
      in_valid8 = 1'b0; a = '1; b = '1; bcast = 1'b0;
      while (busy8 && !out_valid8 && run < 20) begin run++; @(negedge clk); end
      total++; if (run !== 1) $display("FAIL bcast_run_cycles got %0d want 1", run); else passed++;
      total++; if (out_valid8 !== 1'b1) $display("FAIL bcast_valid got %b want 1", out_valid8); else passed++;
      e = sb.pop_front();
      total++; if (result8 !== e.res) $display("FAIL bcast_result got %h want %h", result8, e.res); else passed++;
      total++; if (err8 !== e.err) $display("FAIL bcast_err got %b want %b", err8, e.err); else passed++;
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      vector_t x, y;
      exp_t ex, e;
      for (int i = 0; i < D; i++) begin
         x[i] = 16'sh0200; y[i] = 16'shFF80; ex.res[i] = 16'shFF00;
      end
      ex.err = 1'b0;
      out_ready = 1'b0;
      send(x, y, OP_MUL, ex);
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      total++; if (out_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", out_valid); else passed++;
      e = sb.pop_front();
      a = '0; b = '0; op = OP_ADD; in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e.res || err !== 1'b0)
            $display("FAIL bp_hold cycle %0d got valid=%b ready=%b err=%b res=%h want 1/0/0 %h", k, out_valid, in_ready, err, result, e.res);
         else passed++;
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_release got busy=%b ready=%b valid=%b want 0/1/0", busy, in_ready, out_valid); else passed++;
      @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL bp_ignored got busy=%b want 0", busy); else passed++;
   endtask

   task automatic test_illegal;
      vector_t x;
      exp_t ex, e;
      logic [2:0] bad = 3'b111;
      for (int i = 0; i < D; i++) x[i] = 16'sh0100;
      ex.res = '0; ex.err = 1'b1;
      send(x, x, operation_t'(bad), ex);
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      total++; if (out_valid !== 1'b1) $display("FAIL illegal_valid got %b want 1", out_valid); else passed++;
      e = sb.pop_front();
      total++; if (result !== e.res) $display("FAIL illegal_result got %h want %h", result, e.res); else passed++;
      total++; if (err !== e.err) $display("FAIL illegal_err got %b want %b", err, e.err); else passed++;
      @(negedge clk);
      for (int i = 0; i < D; i++) ex.res[i] = 16'sh0200;
      ex.err = 1'b0;
      send(x, x, OP_ADD, ex);
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      e = sb.pop_front();
      total++; if (result !== e.res || out_valid !== 1'b1) $display("FAIL after_illegal_result got %h valid=%b want %h", result, out_valid, e.res); else passed++;
      total++; if (err !== e.err) $display("FAIL after_illegal_err got %b want %b", err, e.err); else passed++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run;
      vector_t x;
      exp_t ex, e;
      int seen = 0;
      for (int i = 0; i < D; i++) x[i] = 16'sh0100;
      send(x, x, OP_ADD, model(x, x, OP_ADD));
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || out_valid !== 1'b0 || result !== '0) $display("FAIL midrun_reset got busy=%b valid=%b res=%h want 0/0/0", busy, out_valid, result); else passed++;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL midrun_release got ready=%b busy=%b want 1/0", in_ready, busy); else passed++;
      repeat (6) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      total++; if (seen !== 0) $display("FAIL midrun_no_valid got %0d pulses want 0", seen); else passed++;
      for (int i = 0; i < D; i++) begin x[i] = '0; ex.res[i] = 16'sh0100; end
      ex.err = 1'b0;
      send(x, x, OP_EXP, ex);
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      e = sb.pop_front();
      total++; if (result !== e.res || out_valid !== 1'b1) $display("FAIL exp_result got %h valid=%b want %h", result, out_valid, e.res); else passed++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      operation_t ops[4] = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV};
      vector_t x, y;
      exp_t e;
      int acc[$];
      out_ready = 1'b1; bcast = 1'b0; in_valid = 1'b1;
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < D; i++) begin
            x[i] = fixed_point_t'(int'($urandom_range(0, 2047)) - 1024);
            y[i] = fixed_point_t'(int'($urandom_range(0, 2047)) - 1024);
         end
         a = x; b = y; op = ops[$urandom_range(0, 3)];
         for (int k = 0; k < 20 && !in_ready; k++) begin
            if (out_valid) begin
               e = sb.pop_front();
               total++; if (result !== e.res || err !== e.err) $display("FAIL b2b_result got %h err=%b want %h err=%b", result, err, e.res, e.err); else passed++;
            end
            @(negedge clk);
         end
         total++; if (in_ready !== 1'b1) $display("FAIL b2b_accept_timeout got ready=%b want 1", in_ready); else passed++;
         acc.push_back(cyc);
         sb.push_back(model(x, y, op));
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 20 && sb.size() > 0; k++) begin
         if (out_valid) begin
            e = sb.pop_front();
            total++; if (result !== e.res || err !== e.err) $display("FAIL b2b_result got %h err=%b want %h err=%b", result, err, e.res, e.err); else passed++;
         end
         @(negedge clk);
      end
      total++; if (sb.size() !== 0) $display("FAIL b2b_drain got %0d pending want 0", sb.size()); else passed++;
      for (int r = 1; r < acc.size(); r++) begin
         total++; if (acc[r] - acc[r-1] !== 6) $display("FAIL b2b_spacing got %0d want 6", acc[r] - acc[r-1]); else passed++;
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_bcast;
      test_backpressure;
      test_illegal;
      test_reset_mid_run;
      test_back_to_back;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
